// File: rtl/led_pattern_gen.sv
// LED pattern generator: bounce, rotate-left, rotate-right and fill
// sequences stepped by a programmable-period tick counter.
module led_pattern_gen #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int N_LEDS          = 6,
  parameter int STEP_MS         = 100,
  parameter bit ACTIVE_LOW      = 1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [1:0]        Mode,
  input  logic [1:0]        Speed,
  input  logic              Pause,
  output logic [N_LEDS-1:0] Leds,
  output logic              Step_pulse,
  output logic              End_pulse
);

  localparam int STEP_RAW = (CLOCK_FREQUENCY / 1000) * STEP_MS;
  localparam int STEP_CYCLES = (STEP_RAW < 1) ? 1 : STEP_RAW;
  localparam int CW = $clog2(4 * STEP_CYCLES) + 1;

  localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] ALL = '1;

  typedef enum logic [1:0] {
    M_BOUNCE = 2'd0,
    M_ROTL   = 2'd1,
    M_ROTR   = 2'd2,
    M_FILL   = 2'd3
  } mode_t;

  mode_t             mode_q;
  mode_t             mode_d;
  mode_t             mode_in;
  logic [N_LEDS-1:0] pat_q;
  logic [N_LEDS-1:0] pat_d;
  logic              dir_q;
  logic              dir_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [CW-1:0]     term;
  logic              step;
  logic              step_q;
  logic              end_q;
  logic              end_d;

  assign mode_in = mode_t'(Mode);

  // Terminal tracks Speed every cycle; >= catches a shrunk period
  always_comb begin
    term = CW'(STEP_CYCLES) * (CW'(Speed) + CW'(1)) - CW'(1);
    step = !Pause && (cnt_q >= term);
    cnt_d = cnt_q;
    if (!Pause) begin
      cnt_d = step ? '0 : cnt_q + CW'(1);
    end
  end

  always_comb begin
    mode_d = mode_q;
    pat_d  = pat_q;
    dir_d  = dir_q;
    end_d  = 1'b0;
    if (step) begin
      if (mode_in != mode_q) begin
        mode_d = mode_in;
        pat_d  = ONE;
        dir_d  = 1'b1;
      end else begin
        unique case (mode_q)
          M_BOUNCE: begin
            if (dir_q && pat_q[N_LEDS-1]) begin
              pat_d = pat_q >> 1;
              dir_d = 1'b0;
            end else if (!dir_q && pat_q[0]) begin
              pat_d = pat_q << 1;
              dir_d = 1'b1;
            end else begin
              pat_d = dir_q ? (pat_q << 1) : (pat_q >> 1);
            end
            end_d = pat_d[N_LEDS-1] | pat_d[0];
          end
          M_ROTL: begin
            pat_d = {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
            end_d = pat_d[0];
          end
          M_ROTR: begin
            pat_d = {pat_q[0], pat_q[N_LEDS-1:1]};
            end_d = pat_d[N_LEDS-1];
          end
          M_FILL: begin
            if (pat_q == ALL) begin
              pat_d = ONE;
            end else begin
              pat_d = {pat_q[N_LEDS-2:0], 1'b1};
            end
            end_d = (pat_d == ALL);
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_q <= M_BOUNCE;
      pat_q  <= ONE;
      dir_q  <= 1'b1;
      cnt_q  <= '0;
      step_q <= 1'b0;
      end_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      pat_q  <= pat_d;
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
      step_q <= step;
      end_q  <= end_d;
    end
  end

  assign Leds       = ACTIVE_LOW ? ~pat_q : pat_q;
  assign Step_pulse = step_q;
  assign End_pulse  = end_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen with N_LEDS=4, STEP_CYCLES=4,
// plus an ACTIVE_LOW=1 twin sharing the same stimulus.
module tb_led_pattern_gen;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [1:0] Mode = 2'd0;
  logic [1:0] Speed = 2'd0;
  logic       Pause = 1'b0;
  logic [3:0] Leds;
  logic       Step_pulse;
  logic       End_pulse;
  logic [3:0] leds_n;
  logic       step_n;
  logic       end_n;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] leds;
    logic       endp;
    int         gap;
  } exp_t;

  exp_t sb[$];

  led_pattern_gen #(
    .CLOCK_FREQUENCY(1000),
    .N_LEDS(4),
    .STEP_MS(4),
    .ACTIVE_LOW(0)
  ) dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .Mode(Mode),
    .Speed(Speed),
    .Pause(Pause),
    .Leds(Leds),
    .Step_pulse(Step_pulse),
    .End_pulse(End_pulse)
  );

  led_pattern_gen #(
    .CLOCK_FREQUENCY(1000),
    .N_LEDS(4),
    .STEP_MS(4),
    .ACTIVE_LOW(1)
  ) dut_n (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .Mode(Mode),
    .Speed(Speed),
    .Pause(Pause),
    .Leds(leds_n),
    .Step_pulse(step_n),
    .End_pulse(end_n)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input logic [3:0] l,
                      input logic e,
                      input int g);
    exp_t x;
    x.leds = l;
    x.endp = e;
    x.gap  = g;
    sb.push_back(x);
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if (Leds !== 4'b0001) begin
      errors++;
      $display("FAIL %s leds: got %b want 0001", name, Leds);
    end
    checks++;
    if (leds_n !== 4'b1110) begin
      errors++;
      $display("FAIL %s leds_n: got %b want 1110", name, leds_n);
    end
    checks++;
    if ({Step_pulse, End_pulse, step_n, end_n} !== 4'b0) begin
      errors++;
      $display("FAIL %s pulses: got %b want 0000", name,
               {Step_pulse, End_pulse, step_n, end_n});
    end
  endtask

  task automatic quiet(input string name, input int n);
    logic [3:0] held;
    logic ok;
    held = Leds;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (Step_pulse || End_pulse || Leds !== held) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s quiet: got activity want none", name);
    end
  endtask

  task automatic drain(input string name);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.gap > 1) quiet(name, e.gap - 1);
      tick();
      checks++;
      if (Step_pulse !== 1'b1) begin
        errors++;
        $display("FAIL %s step: got %b want 1", name, Step_pulse);
      end
      checks++;
      if (Leds !== e.leds) begin
        errors++;
        $display("FAIL %s leds: got %b want %b", name, Leds, e.leds);
      end
      checks++;
      if (End_pulse !== e.endp) begin
        errors++;
        $display("FAIL %s end: got %b want %b", name, End_pulse, e.endp);
      end
      checks++;
      if (leds_n !== ~e.leds) begin
        errors++;
        $display("FAIL %s leds_n: got %b want %b", name, leds_n, ~e.leds);
      end
    end
  endtask

  task automatic do_reset();
    #2;
    Reset_n = 1'b0;
    #1;
    check_reset_state("reset_async");
    tick();
    tick();
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    Mode = 2'd0;
    Speed = 2'd0;
    Pause = 1'b0;
    Reset_n = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    Reset_n = 1'b1;
  endtask

  task automatic test_bounce();
    push(4'b0010, 1'b0, 4);
    push(4'b0100, 1'b0, 4);
    push(4'b1000, 1'b1, 4);
    push(4'b0100, 1'b0, 4);
    push(4'b0010, 1'b0, 4);
    push(4'b0001, 1'b1, 4);
    push(4'b0010, 1'b0, 4);
    drain("bounce");
  endtask

  task automatic test_fill();
    Mode = 2'd3;
    Speed = 2'd1;
    do_reset();
    push(4'b0001, 1'b0, 8);
    push(4'b0011, 1'b0, 8);
    push(4'b0111, 1'b0, 8);
    push(4'b1111, 1'b1, 8);
    push(4'b0001, 1'b0, 8);
    drain("fill");
  endtask

  task automatic test_rotate_right();
    Mode = 2'd2;
    Speed = 2'd0;
    push(4'b0001, 1'b0, 4);
    push(4'b1000, 1'b1, 4);
    push(4'b0100, 1'b0, 4);
    push(4'b0010, 1'b0, 4);
    push(4'b0001, 1'b0, 4);
    push(4'b1000, 1'b1, 4);
    drain("rotr");
  endtask

  task automatic test_rotate_left();
    Mode = 2'd1;
    push(4'b0001, 1'b0, 4);
    push(4'b0010, 1'b0, 4);
    push(4'b0100, 1'b0, 4);
    push(4'b1000, 1'b0, 4);
    push(4'b0001, 1'b1, 4);
    drain("rotl");
  endtask

  task automatic test_speed_change();
    Speed = 2'd3;
    quiet("speed_slow", 10);
    Speed = 2'd0;
    push(4'b0010, 1'b0, 1);
    push(4'b0100, 1'b0, 4);
    drain("speed_fast");
  endtask

  task automatic test_pause();
    tick();
    tick();
    Pause = 1'b1;
    quiet("pause", 20);
    Pause = 1'b0;
    push(4'b1000, 1'b0, 2);
    push(4'b0001, 1'b1, 4);
    drain("pause_resume");
  endtask

  task automatic test_pause_mode();
    tick();
    tick();
    tick();
    Pause = 1'b1;
    Mode = 2'd3;
    quiet("pause_mode", 5);
    Mode = 2'd1;
    Pause = 1'b0;
    push(4'b0010, 1'b0, 1);
    drain("pause_mode_resume");
  endtask

  task automatic test_reset_mid();
    Mode = 2'd3;
    push(4'b0001, 1'b0, 4);
    push(4'b0011, 1'b0, 4);
    push(4'b0111, 1'b0, 4);
    drain("mid_fill");
    tick();
    tick();
    do_reset();
    push(4'b0001, 1'b0, 4);
    push(4'b0011, 1'b0, 4);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_fill();
    test_rotate_right();
    test_rotate_left();
    test_speed_change();
    test_pause();
    test_pause_mode();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
